control: RTL and testbench

- Multicycle LC-3b control FSM that sits directly upstream of the datapath.
- Sequences fetch/decode/execute and drives every datapath load and select signal plus the memory handshake.
- Consumes the IR opcode and branch_enable from the datapath, and mem_resp from memory.
- Supports ADD, AND, NOT, BR, LDR, STR; every other opcode executes as a NOP.

---
 rtl/lc3b_types.sv | 35 +++
 rtl/control.sv | 144 ++++++++++++++
 tb/tb_control.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: opcodes, ALU functions and the machine word.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

endpackage

// File: rtl/control.sv
// Multicycle LC-3b control FSM (Moore). Drives datapath loads/selects and
// the memory handshake. Optional macro CONTROL_INSTR_CNT_EN adds a 16-bit
// count of decoded instructions on port instr_count.
module control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  lc3b_opcode opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       regfilemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output lc3b_aluop  aluop,
  output logic       mem_read,
  output logic       mem_write,
`ifdef CONTROL_INSTR_CNT_EN
  output lc3b_word   instr_count,
`endif
  output logic [1:0] mem_byte_enable
);

  typedef enum logic [3:0] {
    fetch1, fetch2, fetch3, decode,
    s_add, s_and, s_not,
    br, br_taken,
    calc_addr, ldr1, ldr2, str1, str2
  } state_t;

  state_t state, next_state;

  assign mem_byte_enable = 2'b11;

  // State register; reset always lands in fetch1.
  always_ff @(posedge clk) begin
    if (reset) state <= fetch1;
    else       state <= next_state;
  end

  // Next-state logic; memory states hold until mem_resp.
  always_comb begin
    next_state = fetch1;
    case (state)
      fetch1:    next_state = fetch2;
      fetch2:    next_state = mem_resp ? fetch3 : fetch2;
      fetch3:    next_state = decode;
      decode: begin
        case (opcode)
          op_add:         next_state = s_add;
          op_and:         next_state = s_and;
          op_not:         next_state = s_not;
          op_br:          next_state = br;
          op_ldr, op_str: next_state = calc_addr;
          default:        next_state = fetch1;
        endcase
      end
      br:        next_state = branch_enable ? br_taken : fetch1;
      calc_addr: next_state = (opcode == op_ldr) ? ldr1 : str1;
      ldr1:      next_state = mem_resp ? ldr2 : ldr1;
      str1:      next_state = str2;
      str2:      next_state = mem_resp ? fetch1 : str2;
      default:   next_state = fetch1;
    endcase
  end

  // Moore outputs; reset masks them so an aborted memory request drops at once.
  always_comb begin
    load_pc        = 1'b0;
    load_ir        = 1'b0;
    load_regfile   = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_cc        = 1'b0;
    pcmux_sel      = 1'b0;
    storemux_sel   = 1'b0;
    alumux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    aluop          = alu_add;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (!reset) begin
      case (state)
        fetch1: begin
          marmux_sel = 1'b1;
          load_mar   = 1'b1;
          load_pc    = 1'b1;
        end
        fetch2, ldr1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        fetch3: load_ir = 1'b1;
        s_add, s_and, s_not: begin
          aluop        = (state == s_and) ? alu_and :
                         (state == s_not) ? alu_not : alu_add;
          load_regfile = 1'b1;
          load_cc      = 1'b1;
        end
        br_taken: begin
          pcmux_sel = 1'b1;
          load_pc   = 1'b1;
        end
        calc_addr: begin
          alumux_sel = 1'b1;
          load_mar   = 1'b1;
        end
        ldr2: begin
          regfilemux_sel = 1'b1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        str1: begin
          storemux_sel = 1'b1;
          aluop        = alu_pass;
          load_mdr     = 1'b1;
        end
        str2: mem_write = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CONTROL_INSTR_CNT_EN
  // Counts decode cycles; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)                instr_count <= '0;
    else if (state == decode) instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: each driven cycle pushes the hand-computed
// output vector; a monitor pops and compares on the falling edge.
module tb_control;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  lc3b_opcode opcode = op_trap;
  logic       branch_enable = 1'b0;
  logic       mem_resp = 1'b1;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
  logic pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
  lc3b_aluop  aluop;
  logic       mem_read, mem_write;
  logic [1:0] mem_byte_enable;
`ifdef CONTROL_INSTR_CNT_EN
  lc3b_word   instr_count;
`endif

  control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_enable(branch_enable),
    .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
    .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
    .load_cc(load_cc), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
    .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
    .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel), .aluop(aluop),
    .mem_read(mem_read), .mem_write(mem_write),
`ifdef CONTROL_INSTR_CNT_EN
    .instr_count(instr_count),
`endif
    .mem_byte_enable(mem_byte_enable)
  );

  always #5 clk = ~clk;

  // Bit order: lpc lir lrf lmar lmdr lcc pcm stm alm rfm marm mdrm rd wr
  localparam logic [13:0] V_DEF  = 14'b00000000000000;
  localparam logic [13:0] V_F1   = 14'b10010000001000;
  localparam logic [13:0] V_F2   = 14'b00001000000110;
  localparam logic [13:0] V_F3   = 14'b01000000000000;
  localparam logic [13:0] V_ALU  = 14'b00100100000000;
  localparam logic [13:0] V_BRT  = 14'b10000010000000;
  localparam logic [13:0] V_CALC = 14'b00010000100000;
  localparam logic [13:0] V_LDR2 = 14'b00100100010000;
  localparam logic [13:0] V_STR1 = 14'b00001001000000;
  localparam logic [13:0] V_STR2 = 14'b00000000000001;

  typedef struct {
    string       nm;
    logic [18:0] ex;
    int          cnt;   // expected instr_count, -1 = not checked
  } entry_t;

  entry_t sb[$];
  int     npass = 0;
  int     ntot  = 0;

  // One cycle of stimulus plus its expected outputs.
  task automatic step(input string nm, input logic [13:0] v, input lc3b_aluop a,
                      input logic rs, input logic [3:0] op, input logic be,
                      input logic rp, input int cnt = -1);
    entry_t e;
    @(posedge clk);
    #1;
    reset = rs; opcode = lc3b_opcode'(op); branch_enable = be; mem_resp = rp;
    e.nm = nm; e.ex = {v, 3'(a), 2'b11}; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Common fetch/decode prologue with zero-wait memory.
  task automatic fetch(input string p, input logic [3:0] op);
    step({p, "_f1"},  V_F1,  alu_add, 1'b0, op, 1'b0, 1'b0);
    step({p, "_f2"},  V_F2,  alu_add, 1'b0, op, 1'b0, 1'b1);
    step({p, "_f3"},  V_F3,  alu_add, 1'b0, op, 1'b0, 1'b0);
    step({p, "_dec"}, V_DEF, alu_add, 1'b0, op, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT against the head of the scoreboard.
  initial begin
    entry_t e;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
               pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel,
               mdrmux_sel, mem_read, mem_write, 3'(aluop), mem_byte_enable};
        ntot++;
        if (act === e.ex) npass++;
        else $display("FAIL %s: got %b expected %b", e.nm, act, e.ex);
`ifdef CONTROL_INSTR_CNT_EN
        if (e.cnt >= 0) begin
          ntot++;
          if (instr_count === 16'(e.cnt)) npass++;
          else $display("FAIL %s_cnt: got %0d expected %0d", e.nm, instr_count, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    // Reset with mem_resp high: outputs at defaults.
    step("rst0", V_DEF, alu_add, 1'b1, 4'b1111, 1'b0, 1'b1);
    step("rst1", V_DEF, alu_add, 1'b1, 4'b1111, 1'b0, 1'b1);
    // ADD with 3 wait cycles in fetch2; stray mem_resp in fetch1 ignored.
    step("add_f1",  V_F1, alu_add, 1'b0, 4'b0001, 1'b0, 1'b1);
    step("add_f2a", V_F2, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    step("add_f2b", V_F2, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    step("add_f2c", V_F2, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    step("add_f2d", V_F2, alu_add, 1'b0, 4'b0001, 1'b0, 1'b1);
    step("add_f3",  V_F3, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    step("add_dec", V_DEF, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    step("add_ex",  V_ALU, alu_add, 1'b0, 4'b0001, 1'b0, 1'b0);
    // BR taken.
    fetch("brt", 4'b0000);
    step("brt_br",  V_DEF, alu_add, 1'b0, 4'b0000, 1'b1, 1'b0);
    step("brt_tk",  V_BRT, alu_add, 1'b0, 4'b0000, 1'b0, 1'b0);
    // BR not taken; branch_enable raised after br must not matter.
    fetch("brn", 4'b0000);
    step("brn_br",  V_DEF, alu_add, 1'b0, 4'b0000, 1'b0, 1'b0);
    // LDR zero-wait.
    fetch("ldr", 4'b0110);
    step("ldr_calc", V_CALC, alu_add, 1'b0, 4'b0110, 1'b1, 1'b0);
    step("ldr_1",    V_F2,   alu_add, 1'b0, 4'b0110, 1'b0, 1'b1);
    step("ldr_2",    V_LDR2, alu_add, 1'b0, 4'b0110, 1'b0, 1'b0);
    // STR with one wait cycle in str2.
    fetch("str", 4'b0111);
    step("str_calc", V_CALC, alu_add,  1'b0, 4'b0111, 1'b0, 1'b1);
    step("str_1",    V_STR1, alu_pass, 1'b0, 4'b0111, 1'b0, 1'b1);
    step("str_2a",   V_STR2, alu_add,  1'b0, 4'b0111, 1'b0, 1'b0);
    step("str_2b",   V_STR2, alu_add,  1'b0, 4'b0111, 1'b0, 1'b1);
    // AND and NOT.
    fetch("and", 4'b0101);
    step("and_ex", V_ALU, alu_and, 1'b0, 4'b0101, 1'b0, 1'b0);
    fetch("not", 4'b1001);
    step("not_ex", V_ALU, alu_not, 1'b0, 4'b1001, 1'b0, 1'b0);
    // LDR aborted by reset in ldr1 (mem_resp during reset ignored).
    fetch("abt", 4'b0110);
    step("abt_calc", V_CALC, alu_add, 1'b0, 4'b0110, 1'b0, 1'b0);
    step("abt_1",    V_F2,   alu_add, 1'b0, 4'b0110, 1'b0, 1'b0);
    step("abt_rst",  V_DEF,  alu_add, 1'b1, 4'b0110, 1'b0, 1'b1);
    // Restart: NOP, BR not taken, AND -> three decodes after reset.
    fetch("nop", 4'b1111);
    fetch("br2", 4'b0000);
    step("br2_br", V_DEF, alu_add, 1'b0, 4'b0000, 1'b0, 1'b0);
    fetch("and2", 4'b0101);
    step("and2_ex", V_ALU, alu_and, 1'b0, 4'b0101, 1'b0, 1'b0, 3);
    step("end_f1",  V_F1,  alu_add, 1'b0, 4'b0000, 1'b0, 1'b0);
    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      ntot++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL timeout: run exceeded time budget");
    $fatal(1);
  end

endmodule
